// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one bus.
// The slave modport is the cache's view; the master modport is the fetch/memory side.
interface icache_if;
  logic [63:0] FE_PC;
  logic        FE_REQ;
  logic        FLUSH;
  logic        ICACHE_R;
  logic [31:0] IC_INSTR;
  logic        IC_IAF;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_ERR;

  modport slave (
    input  FE_PC, FE_REQ, FLUSH, MEM_ACK, MEM_RDATA, MEM_ERR,
    output ICACHE_R, IC_INSTR, IC_IAF, MEM_REQ, MEM_ADDR
  );

  modport master (
    output FE_PC, FE_REQ, FLUSH, MEM_ACK, MEM_RDATA, MEM_ERR,
    input  ICACHE_R, IC_INSTR, IC_IAF, MEM_REQ, MEM_ADDR
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, in-order
// multi-beat line refill, one-cycle access-fault report and whole-cache flush.
module icache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input logic     CLK,
  input logic     RESET,
  icache_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;
  localparam int BASE_W = 64 - OFF_W;
  localparam int BEAT_W = OFF_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, FAULT} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][LINE_WORDS];
  logic [BASE_W-1:0]  base_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               flush_pend_q;

  logic [IDX_W-1:0]   fe_idx;
  logic [BEAT_W-1:0]  fe_word;
  logic [TAG_W-1:0]   fe_tag;
  logic [IDX_W-1:0]   ref_idx;
  logic [TAG_W-1:0]   ref_tag;
  logic               lookup_hit;

  logic start_refill, beat_we, set_line, clr_line, flush_all;

  assign fe_idx     = bus.FE_PC[OFF_W+IDX_W-1:OFF_W];
  assign fe_word    = bus.FE_PC[OFF_W-1:2];
  assign fe_tag     = bus.FE_PC[63:OFF_W+IDX_W];
  assign ref_idx    = base_q[IDX_W-1:0];
  assign ref_tag    = base_q[BASE_W-1:IDX_W];
  assign lookup_hit = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_refill = 1'b0;
    beat_we      = 1'b0;
    set_line     = 1'b0;
    clr_line     = 1'b0;
    flush_all    = 1'b0;
    bus.ICACHE_R = 1'b0;
    bus.IC_INSTR = '0;
    bus.IC_IAF   = 1'b0;
    bus.MEM_REQ  = 1'b0;
    bus.MEM_ADDR = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.FLUSH) begin
          flush_all = 1'b1;
        end else if (bus.FE_REQ) begin
          if (lookup_hit) begin
            bus.ICACHE_R = 1'b1;
            bus.IC_INSTR = data_q[fe_idx][fe_word];
          end else begin
            start_refill = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        bus.MEM_REQ  = 1'b1;
        bus.MEM_ADDR = {base_q, {OFF_W{1'b0}}};
        if (bus.MEM_ACK) begin
          if (bus.MEM_ERR) begin
            clr_line = 1'b1;
            state_d  = FAULT;
          end else begin
            beat_we = 1'b1;
            // A flush seen at any point of the refill wins over validating the new line.
            if (beat_q == LAST_BEAT) begin
              state_d = IDLE;
              if (flush_pend_q || bus.FLUSH) flush_all = 1'b1;
              else                           set_line  = 1'b1;
            end
          end
        end
      end
      FAULT: begin
        bus.ICACHE_R = 1'b1;
        bus.IC_IAF   = 1'b1;
        flush_all    = bus.FLUSH || flush_pend_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      base_q       <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      if (start_refill) begin
        base_q <= bus.FE_PC[63:OFF_W];
        beat_q <= '0;
      end else if (beat_we && (beat_q != LAST_BEAT)) begin
        beat_q <= beat_q + 1'b1;
      end

      if ((state_q == FAULT) || ((state_q == REFILL) && (state_d == IDLE)))
        flush_pend_q <= 1'b0;
      else if ((state_q == REFILL) && bus.FLUSH)
        flush_pend_q <= 1'b1;

      if (flush_all)     valid_q          <= '0;
      else if (set_line) valid_q[ref_idx] <= 1'b1;
      else if (clr_line) valid_q[ref_idx] <= 1'b0;
    end
  end

  // Tag and data storage need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (beat_we)  data_q[ref_idx][beat_q] <= bus.MEM_RDATA;
    if (set_line) tag_q[ref_idx]          <= ref_tag;
  end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, multi-cycle corner sequences, and
// randomized fetches checked against a line-level model of the cache.
module tb_icache;
  logic CLK;
  logic RESET;
  icache_if bus();

  icache #(.LINES(64), .LINE_WORDS(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder settings and state
  int          max_gap  = 0;
  int          rsp_beat = 0;
  int          gap_left = 1;
  int          ack_beat = -1;
  logic        err_en   = 1'b0;
  logic [63:0] err_addr = '0;
  logic [63:0] rsp_addr;

  // Reference model: which line base each set currently holds
  logic        m_valid [64];
  logic [59:0] m_base  [64];

  typedef struct {
    logic [63:0] pc;
    logic        pre_flush;
    logic        inject_err;
    logic        exp_miss;
    logic        exp_iaf;
    logic [31:0] exp_instr;
    logic [63:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h1000: return 32'h0000_0013;
      64'h1004: return 32'h0010_0093;
      64'h1008: return 32'h0020_0113;
      64'h100C: return 32'h0030_0193;
      default:  return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered memory: first beat one cycle after MEM_REQ is seen, then 0..max_gap idle cycles between beats
  initial begin
    bus.MEM_ACK   = 1'b0;
    bus.MEM_ERR   = 1'b0;
    bus.MEM_RDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.MEM_ACK   = 1'b0;
      bus.MEM_ERR   = 1'b0;
      bus.MEM_RDATA = '0;
      if (!bus.MEM_REQ) begin
        rsp_beat = 0;
        gap_left = 1;
      end else if (gap_left > 0) begin
        gap_left--;
      end else begin
        rsp_addr      = bus.MEM_ADDR + 64'(rsp_beat * 4);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = mem_word(rsp_addr);
        bus.MEM_ERR   = err_en && (rsp_addr == err_addr);
        ack_beat      = rsp_beat;
        rsp_beat++;
        gap_left      = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Holds FE_REQ until the cache answers; reports refill address, its stability and answer latency
  task automatic apply_stimulus(input logic [63:0] pc, output logic was_miss, output logic got_r,
                                output logic got_iaf, output logic [31:0] got_instr,
                                output logic [63:0] got_addr, output logic addr_stable,
                                output int latency, output int last_ack);
    bus.FE_PC  = pc;
    bus.FE_REQ = 1'b1;
    was_miss = 1'b0; got_r = 1'b0; got_iaf = 1'b0; got_instr = '0;
    got_addr = '0; addr_stable = 1'b1; latency = -1; last_ack = -1;
    for (int c = 0; c < 64 && !got_r; c++) begin
      @(negedge CLK);
      if (bus.MEM_REQ) begin
        if (!was_miss) got_addr = bus.MEM_ADDR;
        else if (bus.MEM_ADDR !== got_addr) addr_stable = 1'b0;
        was_miss = 1'b1;
        if (bus.MEM_ACK) last_ack = c;
      end
      if (bus.ICACHE_R) begin
        got_r     = 1'b1;
        got_iaf   = bus.IC_IAF;
        got_instr = bus.IC_INSTR;
        latency   = c;
      end
      @(posedge CLK);
      #1;
    end
    bus.FE_REQ = 1'b0;
  endtask

  task automatic flush_pulse(input logic [63:0] pc);
    bus.FE_PC  = pc;
    bus.FE_REQ = 1'b1;
    bus.FLUSH  = 1'b1;
    @(negedge CLK);
    check_output("flush_cycle_r", bus.ICACHE_R, 1'b0);
    @(posedge CLK);
    #1;
    bus.FLUSH  = 1'b0;
    bus.FE_REQ = 1'b0;
    @(negedge CLK);
    check_output("flush_no_refill", bus.MEM_REQ, 1'b0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic        miss, r, iaf, stable, found, bad;
    logic [31:0] instr;
    logic [63:0] addr, pc, base;
    int          lat, lack, idx;
    logic        hit_pred, do_err;

    vecs[0] = '{64'h1000, 0, 0, 1, 0, 32'h0000_0013, 64'h1000, 6};
    vecs[1] = '{64'h1008, 0, 0, 0, 0, 32'h0020_0113, 64'h0,    0};
    vecs[2] = '{64'h100E, 0, 0, 0, 0, 32'h0030_0193, 64'h0,    0};
    vecs[3] = '{64'h1400, 0, 0, 1, 0, mem_word(64'h1400), 64'h1400, 6};
    vecs[4] = '{64'h1000, 0, 0, 1, 0, 32'h0000_0013, 64'h1000, 6};
    vecs[5] = '{64'h1004, 0, 0, 0, 0, 32'h0010_0093, 64'h0,    0};
    vecs[6] = '{64'h2000, 0, 1, 1, 1, 32'h0,         64'h2000, 5};
    vecs[7] = '{64'h2000, 0, 0, 1, 0, mem_word(64'h2000), 64'h2000, 6};
    vecs[8] = '{64'h2004, 0, 0, 0, 0, mem_word(64'h2004), 64'h0, 0};
    vecs[9] = '{64'h1004, 1, 0, 1, 0, 32'h0010_0093, 64'h1000, 6};

    RESET = 1'b0;
    bus.FE_PC = '0; bus.FE_REQ = 1'b0; bus.FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check_output("reset_icache_r", bus.ICACHE_R, 1'b0);
    check_output("reset_mem_req",  bus.MEM_REQ,  1'b0);
    check_output("reset_mem_addr", bus.MEM_ADDR, 64'h0);
    check_output("reset_iaf",      bus.IC_IAF,   1'b0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_flush) flush_pulse(vecs[i].pc);
      err_en   = vecs[i].inject_err;
      err_addr = {vecs[i].pc[63:4], 4'h8};
      apply_stimulus(vecs[i].pc, miss, r, iaf, instr, addr, stable, lat, lack);
      err_en = 1'b0;
      check_output($sformatf("vec%0d_miss", i),  miss,  vecs[i].exp_miss);
      check_output($sformatf("vec%0d_r", i),     r,     1'b1);
      check_output($sformatf("vec%0d_iaf", i),   iaf,   vecs[i].exp_iaf);
      check_output($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      check_output($sformatf("vec%0d_addr", i),  addr,  vecs[i].exp_addr);
      check_output($sformatf("vec%0d_lat", i),   64'(lat), 64'(vecs[i].exp_lat));
    end

    $display("[TB] gapped refill");
    max_gap = 3;
    apply_stimulus(64'h6000, miss, r, iaf, instr, addr, stable, lat, lack);
    check_output("gap_miss",   miss,   1'b1);
    check_output("gap_addr",   addr,   64'h6000);
    check_output("gap_stable", stable, 1'b1);
    check_output("gap_lat",    64'(lat), 64'(lack + 1));
    for (int w = 0; w < 4; w++) begin
      apply_stimulus(64'h6000 + 64'(w * 4), miss, r, iaf, instr, addr, stable, lat, lack);
      check_output($sformatf("gap_word%0d", w), instr, mem_word(64'h6000 + 64'(w * 4)));
      check_output($sformatf("gap_hit%0d", w),  miss,  1'b0);
    end

    $display("[TB] flush during refill");
    max_gap = 1;
    bus.FE_PC = 64'h3000; bus.FE_REQ = 1'b1;
    @(posedge CLK); #1;
    bus.FE_REQ = 1'b0; bus.FE_PC = 64'h1004; bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    found = 1'b0; bad = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge CLK);
      if (!bus.MEM_REQ) found = 1'b1;
      else if (bus.MEM_ADDR !== 64'h3000) bad = 1'b1;
    end
    check_output("midflush_drained",     found, 1'b1);
    check_output("midflush_addr_stable", bad,   1'b0);
    @(posedge CLK); #1;
    max_gap = 0;
    apply_stimulus(64'h3000, miss, r, iaf, instr, addr, stable, lat, lack);
    check_output("midflush_refetch_miss", miss,  1'b1);
    check_output("midflush_refetch_data", instr, mem_word(64'h3000));
    apply_stimulus(64'h6004, miss, r, iaf, instr, addr, stable, lat, lack);
    check_output("midflush_old_line_miss", miss, 1'b1);

    $display("[TB] reset during refill");
    bus.FE_PC = 64'h5000; bus.FE_REQ = 1'b1;
    @(posedge CLK); #1;
    bus.FE_REQ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 32 && !found; c++) begin
      @(negedge CLK);
      if (bus.MEM_ACK && bus.MEM_REQ && ack_beat == 1) found = 1'b1;
    end
    check_output("rst_reached_beat1", found, 1'b1);
    RESET = 1'b0;
    #1;
    check_output("rst_async_mem_req",  bus.MEM_REQ,  1'b0);
    check_output("rst_async_mem_addr", bus.MEM_ADDR, 64'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    apply_stimulus(64'h5000, miss, r, iaf, instr, addr, stable, lat, lack);
    check_output("rst_refetch_miss", miss,  1'b1);
    check_output("rst_refetch_data", instr, mem_word(64'h5000));

    $display("[TB] randomized fetches against model");
    flush_pulse(64'h0);
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_base[i]  = '0;
    end
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(9, 0) == 0) begin
        flush_pulse(64'($urandom));
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      end
      pc = (64'($urandom_range(3, 0)) << 62) | 64'h40000
         | (64'($urandom_range(7, 0)) << 4) | (64'($urandom_range(3, 0)) << 2)
         | 64'($urandom_range(3, 0));
      base     = pc >> 4;
      idx      = int'(base % 64);
      hit_pred = m_valid[idx] && (m_base[idx] == base[59:0]);
      do_err   = ($urandom_range(5, 0) == 0);
      max_gap  = int'($urandom_range(3, 0));
      err_en   = do_err;
      err_addr = (base << 4) + 64'($urandom_range(3, 0) * 4);
      apply_stimulus(pc, miss, r, iaf, instr, addr, stable, lat, lack);
      err_en = 1'b0;
      check_output($sformatf("rnd%0d_miss", t), miss, !hit_pred);
      check_output($sformatf("rnd%0d_r", t),    r,    1'b1);
      if (hit_pred) begin
        check_output($sformatf("rnd%0d_instr", t), instr, mem_word({pc[63:2], 2'b00}));
        check_output($sformatf("rnd%0d_lat", t),   64'(lat), 64'h0);
      end else begin
        check_output($sformatf("rnd%0d_addr", t),   addr,   base << 4);
        check_output($sformatf("rnd%0d_stable", t), stable, 1'b1);
        check_output($sformatf("rnd%0d_lat", t),    64'(lat), 64'(lack + 1));
        check_output($sformatf("rnd%0d_iaf", t),    iaf,    do_err);
        check_output($sformatf("rnd%0d_instr", t),  instr,
                     do_err ? 32'h0 : mem_word({pc[63:2], 2'b00}));
        m_valid[idx] = !do_err;
        m_base[idx]  = base[59:0];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache directly upstream of the fetch stage. It returns the 32-bit instruction at the fetch PC on a hit in the same cycle. On a miss it runs a multi-beat line refill from the memory port and reports instruction access faults to fetch. FLUSH (FENCE.I) invalidates the whole cache.

## Interface
- LINES, 64: number of lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.
- Derived: OFF_W = log2(LINE_WORDS*4) = 4; IDX_W = log2(LINES) = 6; TAG_W = 64 − OFF_W − IDX_W = 54.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FE_PC  in  64  fetch PC; bits [1:0] ignored.
- FE_REQ  in  1  fetch wants an instruction this cycle.
- FLUSH  in  1  invalidate all lines.
- ICACHE_R  out  1  IC_INSTR/IC_IAF valid for FE_PC this cycle.
- IC_INSTR  out  32  instruction word; 0 when ICACHE_R=0.
- IC_IAF  out  1  access fault for FE_PC; only with ICACHE_R=1.
- MEM_REQ  out  1  refill request, held for the whole refill.
- MEM_ADDR  out  64  line-aligned refill address (low OFF_W bits 0).
- MEM_ACK  in  1  one beat delivered this cycle.
- MEM_RDATA  in  32  beat data, valid with MEM_ACK.
- MEM_ERR  in  1  beat faulted, valid with MEM_ACK.

## Operation
- Storage: valid[LINES], tag[LINES][TAG_W], data[LINES][LINE_WORDS][32], all flops. Index = FE_PC[OFF_W+IDX_W−1:OFF_W]. Word = FE_PC[OFF_W−1:2].
- Hit = FE_REQ and state IDLE and valid[idx] and tag[idx] == FE_PC[63:OFF_W+IDX_W]. On a hit, ICACHE_R=1 and IC_INSTR = data[idx][word], combinationally.
- FSM has states IDLE, REFILL and FAULT.
- IDLE: on FE_REQ with a miss (and FLUSH=0), latch the line base FE_PC[63:OFF_W] and the index, clear the beat counter and go to REFILL.
- REFILL: MEM_REQ=1 and MEM_ADDR = latched base. MEM_ADDR is stable for the whole state.
  - Each MEM_ACK with MEM_ERR=0 writes MEM_RDATA into data[idx][beat] and increments beat. Beats arrive in order 0..LINE_WORDS−1.
  - After the beat LINE_WORDS−1 is acked: set valid[idx] and tag[idx], go to IDLE. The next cycle hits.
  - MEM_ACK with MEM_ERR=1 on any beat: valid[idx] cleared, go to FAULT. No further beats are expected; memory ends the burst.
- FAULT: exactly one cycle with ICACHE_R=1, IC_INSTR=0, IC_IAF=1, then go to IDLE. The line stays invalid, so re-fetching the same PC re-requests it.
- FLUSH in IDLE: all valid bits are cleared at the next edge. ICACHE_R=0 that cycle, and no refill is started.
- FLUSH during REFILL: a sticky flush_pend flag is set and the refill drains normally.
  - At completion, all valid bits are cleared and the refilled line is not validated.
  - FLUSH during FAULT is applied the same cycle.
- A change in FE_PC or FE_REQ during REFILL does not abort the refill. The lookup of the new PC happens only after returning to IDLE.
- No writes from the pipeline; cache data is read-only.

## Timing
- Reset (RESET=0, async): state=IDLE, all valid=0, beat=0, flush_pend=0. Outputs: ICACHE_R=0, IC_INSTR=0, IC_IAF=0, MEM_REQ=0, MEM_ADDR=0.
- Reset mid-refill aborts immediately: MEM_REQ drops asynchronously and no line is validated.
- Hit latency is 0 cycles (combinational).
- Miss latency is 1 cycle (IDLE→REFILL), plus the LINE_WORDS ack cycles, plus 1 cycle for the hit in IDLE.
  - With ack every cycle and LINE_WORDS=4, ICACHE_R rises 6 cycles after the missing FE_REQ cycle.
- ICACHE_R=0 for the whole of REFILL, including the last-beat cycle.
- MEM_ACK while MEM_REQ=0 is ignored.
- The beat counter is OFF_W−2 bits wide and never wraps: leaving REFILL happens on the last beat.
- A miss can only start from IDLE, so at most one refill is outstanding.

## Test plan
- Cold miss then hit: after reset, FE_REQ=1, FE_PC=0x1000; ack 4 beats back-to-back with 0x00000013, 0x00100093, 0x00200113, 0x00300193.
  - MEM_ADDR=0x1000 held.
  - ICACHE_R=1 with IC_INSTR=0x00000013 at cycle 6.
  - FE_PC=0x1008 then hits immediately with 0x00200113.
- Conflict eviction: fill 0x1000, then fetch 0x1400 (same index 0, different tag).
  - The refill replaces the line.
  - Re-fetching 0x1000 misses again, with MEM_ADDR=0x1000.
- Refill with gaps: acks on cycles separated by 0–3 idle cycles.
  - MEM_REQ and MEM_ADDR stay stable throughout.
  - Data matches beat order.
  - ICACHE_R stays 0 until 1 cycle after the last ack.
- Access fault: MEM_ERR=1 on beat 2 of the 0x2000 refill.
  - A one-cycle ICACHE_R=1, IC_IAF=1, IC_INSTR=0.
  - The next FE_REQ to 0x2000 starts a new refill.
- Flush: FLUSH pulsed in IDLE makes a hit at 0x1000 become a miss. FLUSH pulsed mid-refill of 0x3000 lets the refill finish, but a fetch of 0x3000 misses again.
- Async reset asserted on beat 1 of a refill: MEM_REQ=0 immediately, and after release a fetch of the same PC misses.
